// File: rtl/imm_extender_pipe_pkg.sv
// Shared CPU definitions for the immediate extender: extension mode codes
// and the encoding of the output pipe's occupancy state.
package imm_extender_pipe_pkg;

    localparam int EXT_SEL_W = 3;

    typedef enum logic [EXT_SEL_W-1:0] {
        EXT_SA     = 3'b000,
        EXT_ZERO   = 3'b001,
        EXT_SIGN   = 3'b010,
        EXT_UPPER  = 3'b011,
        EXT_BRANCH = 3'b100
    } ext_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } pipe_state_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Purely combinational immediate extension. Undefined mode codes fall back
// to sign extension and raise the illegal flag.
module imm_ext_comb
    import imm_extender_pipe_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int SA_LSB = 6,
    parameter int SA_W   = 5
) (
    input  logic [IN_W-1:0]      i_num,
    input  logic [EXT_SEL_W-1:0] ExtSel,
    output logic [OUT_W-1:0]     result,
    output logic                 illegal
);

    logic [OUT_W-1:0] sa_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;

    assign sa_ext     = {{(OUT_W-SA_W){1'b0}}, i_num[SA_LSB+SA_W-1:SA_LSB]};
    assign zero_ext   = {{(OUT_W-IN_W){1'b0}}, i_num};
    assign sign_ext   = {{(OUT_W-IN_W){i_num[IN_W-1]}}, i_num};
    assign upper_ext  = {i_num, {(OUT_W-IN_W){1'b0}}};
    assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};

    // Pick the extension for the requested mode; unknown codes sign-extend and flag illegal
    always_comb begin
        result  = sign_ext;
        illegal = 1'b0;
        case (ExtSel)
            EXT_SA:     result = sa_ext;
            EXT_ZERO:   result = zero_ext;
            EXT_SIGN:   result = sign_ext;
            EXT_UPPER:  result = upper_ext;
            EXT_BRANCH: result = branch_ext;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extender_pipe.sv
// Immediate extender with a one-cycle registered output stage and a skid
// register, so i_ready can be registered without losing beats under
// backpressure.
module imm_extender_pipe
    import imm_extender_pipe_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int SA_LSB = 6,
    parameter int SA_W   = 5
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [IN_W-1:0]      i_num,
    input  logic [EXT_SEL_W-1:0] ExtSel,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [OUT_W-1:0]     o_num,
    output logic                 o_illegal
);

    logic [OUT_W-1:0] ext_result;
    logic             ext_illegal;

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             i_ready_q;
    logic [OUT_W-1:0] out_num_q;
    logic             out_illegal_q;
    logic [OUT_W-1:0] skid_num_q;
    logic             skid_illegal_q;

    logic accept;
    logic drain;
    logic load_out_from_in;
    logic load_out_from_skid;
    logic load_skid;

    imm_ext_comb #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SA_LSB (SA_LSB),
        .SA_W   (SA_W)
    ) u_ext (
        .i_num   (i_num),
        .ExtSel  (ExtSel),
        .result  (ext_result),
        .illegal (ext_illegal)
    );

    assign accept    = i_valid && i_ready_q;
    assign drain     = o_valid && o_ready;
    assign i_ready   = i_ready_q;
    assign o_valid   = (state_q != ST_EMPTY);
    assign o_num     = out_num_q;
    assign o_illegal = out_illegal_q;

    // Next occupancy state and which register gets loaded from where
    always_comb begin
        state_d            = state_q;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d          = ST_ONE;
                    load_out_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_out_from_in = 1'b1;
                end else if (accept) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d            = ST_ONE;
                    load_out_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Occupancy state register; i_ready is registered from the next state so it never depends combinationally on o_ready
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_EMPTY;
            i_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_ready_q <= (state_d != ST_TWO);
        end
    end

    // Output and skid data registers, cleared on reset so no stale beat survives
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            out_num_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_num_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            if (load_out_from_in) begin
                out_num_q     <= ext_result;
                out_illegal_q <= ext_illegal;
            end else if (load_out_from_skid) begin
                out_num_q     <= skid_num_q;
                out_illegal_q <= skid_illegal_q;
            end
            if (load_skid) begin
                skid_num_q     <= ext_result;
                skid_illegal_q <= ext_illegal;
            end else if (load_out_from_skid) begin
                skid_num_q     <= '0;
                skid_illegal_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Self-checking bench for imm_extender_pipe: a default-parameter instance
// plus an IN_W=8/OUT_W=16 instance, with a scoreboard fed from accepted beats.
module tb_imm_extender_pipe;

    logic        CLK;
    logic        Reset;

    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_num;
    logic [2:0]  ExtSel;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_num;
    logic        o_illegal;

    logic        i_valid8;
    logic        i_ready8;
    logic [7:0]  i_num8;
    logic [2:0]  ext_sel8;
    logic        o_valid8;
    logic        o_ready8;
    logic [15:0] o_num8;
    logic        o_illegal8;

    int          checks;
    int          errors;

    logic [32:0] sb[$];
    logic [16:0] sb8[$];
    logic [32:0] exp32;
    logic [16:0] exp16;

    imm_extender_pipe dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_num     (i_num),
        .ExtSel    (ExtSel),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_num     (o_num),
        .o_illegal (o_illegal)
    );

    imm_extender_pipe #(
        .IN_W   (8),
        .OUT_W  (16),
        .SA_LSB (3),
        .SA_W   (5)
    ) dut8 (
        .CLK       (CLK),
        .Reset     (Reset),
        .i_valid   (i_valid8),
        .i_ready   (i_ready8),
        .i_num     (i_num8),
        .ExtSel    (ext_sel8),
        .o_valid   (o_valid8),
        .o_ready   (o_ready8),
        .o_num     (o_num8),
        .o_illegal (o_illegal8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model for the default instance: {illegal, result}
    function automatic logic [32:0] model32(input logic [15:0] n, input logic [2:0] s);
        logic [31:0] sx;
        sx = {{16{n[15]}}, n};
        case (s)
            3'b000:  return {1'b0, 27'd0, n[10:6]};
            3'b001:  return {1'b0, 16'd0, n};
            3'b010:  return {1'b0, sx};
            3'b011:  return {1'b0, n, 16'd0};
            3'b100:  return {1'b0, sx << 2};
            default: return {1'b1, sx};
        endcase
    endfunction

    // Reference model for the 8-to-16 instance (shift-amount field at bits 7:3)
    function automatic logic [16:0] model16(input logic [7:0] n, input logic [2:0] s);
        logic [15:0] sx;
        sx = {{8{n[7]}}, n};
        case (s)
            3'b000:  return {1'b0, 11'd0, n[7:3]};
            3'b001:  return {1'b0, 8'd0, n};
            3'b010:  return {1'b0, sx};
            3'b011:  return {1'b0, n, 8'd0};
            3'b100:  return {1'b0, sx << 2};
            default: return {1'b1, sx};
        endcase
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b0 || o_num !== 32'h0 || o_illegal !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_outputs: got v=%b rdy=%b num=%h ill=%b, want 0 0 00000000 0", o_valid, i_ready, o_num, o_illegal); end
        checks++;
        if (o_valid8 !== 1'b0 || i_ready8 !== 1'b0 || o_num8 !== 16'h0)
            begin errors++; $display("[TB] FAIL reset_outputs8: got v=%b rdy=%b num=%h, want 0 0 0000", o_valid8, i_ready8, o_num8); end
        repeat (2) @(posedge CLK);
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL ready_before_edge: got %b want 0", i_ready); end
        @(posedge CLK);
        #1;
        checks++;
        if (i_ready !== 1'b1 || i_ready8 !== 1'b1 || o_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL ready_after_release: got rdy=%b rdy8=%b v=%b, want 1 1 0", i_ready, i_ready8, o_valid); end
    endtask

    task automatic test_modes();
        logic [15:0] nums [9];
        logic [2:0]  sels [9];
        logic [31:0] exps [9];
        logic        ills [9];
        nums = '{16'h8001, 16'h8001, 16'h8001, 16'h07C0, 16'h1234, 16'h8000, 16'h7FFF, 16'hA5A5, 16'h0000};
        sels = '{3'b010, 3'b001, 3'b100, 3'b000, 3'b011, 3'b110, 3'b101, 3'b111, 3'b010};
        exps = '{32'hFFFF8001, 32'h00008001, 32'hFFFE0004, 32'h0000001F, 32'h12340000,
                 32'hFFFF8000, 32'h00007FFF, 32'hFFFFA5A5, 32'h00000000};
        ills = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        o_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            i_valid = 1'b1;
            i_num   = nums[k];
            ExtSel  = sels[k];
            @(posedge CLK);
            #1;
            i_valid = 1'b0;
            i_num   = 16'($urandom);
            ExtSel  = 3'($urandom);
            checks++;
            if (o_valid !== 1'b1 || o_num !== exps[k] || o_illegal !== ills[k])
                begin errors++; $display("[TB] FAIL mode_%0d: got v=%b num=%h ill=%b, want 1 %h %b", k, o_valid, o_num, o_illegal, exps[k], ills[k]); end
            @(posedge CLK);
            #1;
            checks++;
            if (o_valid !== 1'b0)
                begin errors++; $display("[TB] FAIL mode_drain_%0d: got v=%b want 0", k, o_valid); end
        end
    endtask

    task automatic test_backpressure();
        o_ready = 1'b0;
        ExtSel  = 3'b001;
        i_valid = 1'b1;
        i_num   = 16'h0001;
        @(posedge CLK);
        #1;
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b1 || o_num !== 32'h1)
            begin errors++; $display("[TB] FAIL bp_first: got rdy=%b v=%b num=%h, want 1 1 00000001", i_ready, o_valid, o_num); end
        i_num = 16'h0002;
        @(posedge CLK);
        #1;
        checks++;
        if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_num !== 32'h1)
            begin errors++; $display("[TB] FAIL bp_full: got rdy=%b v=%b num=%h, want 0 1 00000001", i_ready, o_valid, o_num); end
        i_num  = 16'hDEAD;
        ExtSel = 3'b110;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (i_ready !== 1'b0 || o_num !== 32'h1 || o_illegal !== 1'b0)
                begin errors++; $display("[TB] FAIL bp_hold_%0d: got rdy=%b num=%h ill=%b, want 0 00000001 0", k, i_ready, o_num, o_illegal); end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_num !== 32'h2 || i_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL bp_second: got v=%b num=%h rdy=%b, want 1 00000002 1", o_valid, o_num, i_ready); end
        @(posedge CLK);
        #1;
        checks++;
        if (o_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL bp_empty: got v=%b want 0", o_valid); end
    endtask

    task automatic test_streaming();
        o_ready = 1'b1;
        ExtSel  = 3'b001;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (i_ready !== 1'b1)
                begin errors++; $display("[TB] FAIL stream_ready_%0d: got %b want 1", k, i_ready); end
            i_valid = 1'b1;
            i_num   = 16'(16'h0100 + k);
            @(posedge CLK);
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_num !== 32'(32'h100 + k))
                begin errors++; $display("[TB] FAIL stream_%0d: got v=%b num=%h, want 1 %h", k, o_valid, o_num, 32'(32'h100 + k)); end
        end
        i_valid = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL stream_end: got v=%b rdy=%b, want 0 1", o_valid, i_ready); end
    endtask

    task automatic test_reset_in_two();
        o_ready = 1'b0;
        ExtSel  = 3'b010;
        i_valid = 1'b1;
        i_num   = 16'h8003;
        @(posedge CLK);
        #1;
        i_num = 16'h8004;
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
        checks++;
        if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_num !== 32'hFFFF8003)
            begin errors++; $display("[TB] FAIL r2_full: got rdy=%b v=%b num=%h, want 0 1 ffff8003", i_ready, o_valid, o_num); end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_num !== 32'h0 || o_illegal !== 1'b0 || i_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL r2_async: got v=%b num=%h ill=%b rdy=%b, want 0 00000000 0 0", o_valid, o_num, o_illegal, i_ready); end
        o_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #3;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (i_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL r2_ready: got %b want 1", i_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_valid !== 1'b0)
                begin errors++; $display("[TB] FAIL r2_stale_%0d: got v=%b num=%h, want v=0", k, o_valid, o_num); end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_param_sweep();
        logic [7:0]  nums [5];
        logic [2:0]  sels [5];
        logic [15:0] exps [5];
        logic        ills [5];
        nums = '{8'h80, 8'h80, 8'hF8, 8'h81, 8'h7F};
        sels = '{3'b010, 3'b011, 3'b000, 3'b100, 3'b101};
        exps = '{16'hFF80, 16'h8000, 16'h001F, 16'hFE04, 16'h007F};
        ills = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        o_ready8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_valid8 = 1'b1;
            i_num8   = nums[k];
            ext_sel8 = sels[k];
            @(posedge CLK);
            #1;
            i_valid8 = 1'b0;
            checks++;
            if (o_valid8 !== 1'b1 || o_num8 !== exps[k] || o_illegal8 !== ills[k])
                begin errors++; $display("[TB] FAIL sweep_%0d: got v=%b num=%h ill=%b, want 1 %h %b", k, o_valid8, o_num8, o_illegal8, exps[k], ills[k]); end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        Reset    = 1'b1;
        i_valid  = 1'b0;
        i_num    = 16'h0;
        ExtSel   = 3'b000;
        o_ready  = 1'b1;
        i_valid8 = 1'b0;
        i_num8   = 8'h0;
        ext_sel8 = 3'b000;
        o_ready8 = 1'b1;
        fork
            begin
                // Scoreboard: push expected on accepted input beats, pop and compare on output transfers
                forever begin
                    @(negedge CLK);
                    if (!Reset) begin
                        sb.delete();
                        sb8.delete();
                    end else begin
                        if (o_valid && o_ready) begin
                            checks++;
                            if (sb.size() == 0) begin
                                errors++;
                                $display("[TB] FAIL sb_unexpected: got num=%h ill=%b, want no beat", o_num, o_illegal);
                            end else begin
                                exp32 = sb.pop_front();
                                if ({o_illegal, o_num} !== exp32)
                                    begin errors++; $display("[TB] FAIL sb_beat: got ill=%b num=%h, want ill=%b num=%h", o_illegal, o_num, exp32[32], exp32[31:0]); end
                            end
                        end
                        if (i_valid && i_ready)
                            sb.push_back(model32(i_num, ExtSel));
                        if (o_valid8 && o_ready8) begin
                            checks++;
                            if (sb8.size() == 0) begin
                                errors++;
                                $display("[TB] FAIL sb8_unexpected: got num=%h ill=%b, want no beat", o_num8, o_illegal8);
                            end else begin
                                exp16 = sb8.pop_front();
                                if ({o_illegal8, o_num8} !== exp16)
                                    begin errors++; $display("[TB] FAIL sb8_beat: got ill=%b num=%h, want ill=%b num=%h", o_illegal8, o_num8, exp16[16], exp16[15:0]); end
                            end
                        end
                        if (i_valid8 && i_ready8)
                            sb8.push_back(model16(i_num8, ext_sel8));
                    end
                end
            end
            begin
                test_reset();
                test_modes();
                test_backpressure();
                test_streaming();
                test_reset_in_two();
                test_param_sweep();
                repeat (2) @(posedge CLK);
                #1;
                checks++;
                if (sb.size() != 0 || sb8.size() != 0)
                    begin errors++; $display("[TB] FAIL sb_leftover: got %0d and %0d pending beats, want 0 and 0", sb.size(), sb8.size()); end
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
